// File: rtl/write_burst_sequencer.sv
// Splits a byte-addressed write into bursts that never cross 4 KiB, one generator word per beat.
// Optional build macro: WRITE_SEQUENCER_ABORT_ON_ERROR_EN stops issuing bursts after an error response.
module write_burst_sequencer #(
  parameter int DATA_WIDTH      = 256,
  parameter int ADDR_WIDTH      = 40,
  parameter int LENGTH_WIDTH    = 24,
  parameter int MAX_BURST_BEATS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_address,
  input  logic [LENGTH_WIDTH-1:0] transfer_length,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    gen_initialize,
  output logic                    gen_advance,
  output logic [DATA_WIDTH/8-1:0] gen_byte_mask,
  input  logic [DATA_WIDTH-1:0]   gen_data,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [ADDR_WIDTH-1:0]   aw_address,
  output logic [7:0]              aw_length,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strobe,
  output logic                    w_last,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic                    b_error
);
  localparam int BPB         = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(BPB);
  localparam int BEAT_WIDTH  = LENGTH_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, ADDRESS, DATA, RESPONSE, DONE} state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0]  address_q;
  logic [BEAT_WIDTH-1:0]  remaining_q;
  logic [8:0]             burst_beats_q;
  logic [8:0]             beat_count_q;
  logic [OFFSET_BITS-1:0] tail_q;
  logic                   error_q;
  logic                   init_q;

  logic [BEAT_WIDTH-1:0]  total_beats;
  logic [BEAT_WIDTH-1:0]  page_beats;
  logic [BEAT_WIDTH-1:0]  burst_beats;
  logic [12:0]            page_room;
  logic                   start_accept;
  logic                   aw_fire;
  logic                   w_fire;
  logic                   b_fire;
  logic                   last_burst_beat;
  logic                   final_beat;

  assign start_accept    = (state == IDLE) && start;
  assign aw_fire         = aw_valid && aw_ready;
  assign w_fire          = w_valid && w_ready;
  assign b_fire          = b_ready && b_valid;
  assign total_beats     = (BEAT_WIDTH'(transfer_length) + BEAT_WIDTH'(BPB - 1)) >> OFFSET_BITS;
  assign page_room       = 13'd4096 - {1'b0, address_q[11:0]};
  assign page_beats      = BEAT_WIDTH'(page_room >> OFFSET_BITS);
  assign last_burst_beat = (beat_count_q == burst_beats_q - 9'd1);
  // remaining_q already excludes the burst in flight, so zero means this is the last burst
  assign final_beat      = (state == DATA) && last_burst_beat && (remaining_q == '0);

  always_comb begin
    burst_beats = BEAT_WIDTH'(MAX_BURST_BEATS);
    if (remaining_q < burst_beats) burst_beats = remaining_q;
    if (page_beats < burst_beats) burst_beats = page_beats;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    b_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = (transfer_length == '0) ? DONE : ADDRESS;
      end
      ADDRESS: begin
        busy     = 1'b1;
        aw_valid = 1'b1;
        if (aw_ready) next_state = DATA;
      end
      DATA: begin
        busy    = 1'b1;
        w_valid = 1'b1;
        if (w_ready && last_burst_beat) next_state = RESPONSE;
      end
      RESPONSE: begin
        busy    = 1'b1;
        b_ready = 1'b1;
        if (b_valid) begin
`ifdef WRITE_SEQUENCER_ABORT_ON_ERROR_EN
          next_state = (b_error || remaining_q == '0) ? DONE : ADDRESS;
`else
          next_state = (remaining_q == '0) ? DONE : ADDRESS;
`endif
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_q     <= '0;
      remaining_q   <= '0;
      burst_beats_q <= '0;
      beat_count_q  <= '0;
      tail_q        <= '0;
      error_q       <= 1'b0;
      init_q        <= 1'b0;
    end else begin
      init_q <= start_accept && (transfer_length != '0);
      if (start_accept) begin
        error_q <= 1'b0;
        if (transfer_length != '0) begin
          address_q   <= {start_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          remaining_q <= total_beats;
          tail_q      <= transfer_length[OFFSET_BITS-1:0];
        end
      end
      if (aw_fire) begin
        burst_beats_q <= 9'(burst_beats);
        remaining_q   <= remaining_q - burst_beats;
        beat_count_q  <= '0;
      end
      if (w_fire) beat_count_q <= beat_count_q + 9'd1;
      if (b_fire) begin
        error_q   <= error_q | b_error;
        address_q <= address_q + (ADDR_WIDTH'(burst_beats_q) << OFFSET_BITS);
      end
    end
  end

  // Only the very last beat of a transfer with a partial tail is trimmed
  always_comb begin
    gen_byte_mask = '1;
    if (final_beat && (tail_q != '0)) begin
      for (int i = 0; i < BPB; i++) gen_byte_mask[i] = (i < int'(tail_q));
    end
  end

  assign gen_initialize = init_q;
  assign gen_advance    = w_fire;
  assign error          = error_q;
  assign aw_address     = address_q;
  assign aw_length      = aw_valid ? 8'(burst_beats - BEAT_WIDTH'(1)) : 8'd0;
  assign w_data         = gen_data;
  assign w_strobe       = gen_byte_mask;
  assign w_last         = w_valid && last_burst_beat;

endmodule

// File: tb/tb_write_burst_sequencer.sv
// Self-checking bench for write_burst_sequencer: randomized bus handshakes with a stub generator
// and a burst-splitting reference model computed from address/length arithmetic.
module tb_write_burst_sequencer;
  localparam int DW = 256;
  localparam int AW = 40;
  localparam int LW = 24;
  localparam int MAXB = 16;
  localparam int BPB = DW / 8;
`ifdef WRITE_SEQUENCER_ABORT_ON_ERROR_EN
  localparam bit ABORT_ON_ERROR = 1'b1;
`else
  localparam bit ABORT_ON_ERROR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic [AW-1:0] start_address;
  logic [LW-1:0] transfer_length;
  logic busy, done, error, gen_initialize, gen_advance;
  logic [BPB-1:0] gen_byte_mask;
  logic [DW-1:0] gen_data;
  logic aw_valid, aw_ready;
  logic [AW-1:0] aw_address;
  logic [7:0] aw_length;
  logic w_valid, w_ready, w_last;
  logic [DW-1:0] w_data;
  logic [BPB-1:0] w_strobe;
  logic b_valid, b_ready, b_error;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  write_burst_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .start_address(start_address),
    .transfer_length(transfer_length), .busy(busy), .done(done), .error(error),
    .gen_initialize(gen_initialize), .gen_advance(gen_advance), .gen_byte_mask(gen_byte_mask),
    .gen_data(gen_data), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
    .aw_length(aw_length), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_strobe(w_strobe), .w_last(w_last), .b_valid(b_valid), .b_ready(b_ready), .b_error(b_error)
  );

  // Stub pattern generator: word index restarts on gen_initialize, steps on gen_advance
  logic [31:0] seed = 32'h0;
  int unsigned gen_index;

  function automatic logic [DW-1:0] pattern_word(input int unsigned idx, input logic [31:0] s);
    logic [DW-1:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = (32'(idx + 1) * 32'h9E3779B9) ^ s ^ (32'h01010101 * 32'(i));
    return w;
  endfunction

  function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] w, input logic [BPB-1:0] m);
    for (int i = 0; i < BPB; i++) if (!m[i]) w[8*i +: 8] = 8'h00;
    return w;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) gen_index <= 0;
    else if (gen_initialize) gen_index <= 0;
    else if (gen_advance) gen_index <= gen_index + 1;
  end

  assign gen_data = apply_mask(pattern_word(gen_index, seed), gen_byte_mask);

  // Observations of one transfer
  logic [AW-1:0] obs_aw_addr[$];
  logic [7:0] obs_aw_len[$];
  logic [DW-1:0] obs_data[$];
  logic [BPB-1:0] obs_strobe[$];
  bit obs_last[$];
  int obs_adv, obs_init, obs_done_lat, obs_stable_viol, obs_overlap;
  bit obs_busy1, obs_awv1, obs_init1, obs_busy_done, obs_timeout, obs_after_ok;
  logic obs_error;

  task automatic run_transfer(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                              input int mode, input bit err_first);
    int cyc, last_hs, b_count;
    bit outstanding, b_phase, tog, fin, aw_stall, w_stall;
    logic [AW-1:0] st_addr;
    logic [7:0] st_len;
    logic [DW-1:0] st_data;
    logic [BPB-1:0] st_strb;
    logic st_last;
    obs_aw_addr.delete(); obs_aw_len.delete(); obs_data.delete(); obs_strobe.delete(); obs_last.delete();
    obs_adv = 0; obs_init = 0; obs_done_lat = -99; obs_stable_viol = 0; obs_overlap = 0;
    obs_busy_done = 1'b1; obs_error = 1'bx;
    cyc = 0; last_hs = -1; b_count = 0; outstanding = 0; b_phase = 0; tog = 0; fin = 0;
    aw_stall = 0; w_stall = 0; st_addr = '0; st_len = '0; st_data = '0; st_strb = '0; st_last = 0;
    seed = $urandom;
    @(negedge clock);
    start = 1'b1; start_address = addr; transfer_length = len;
    @(negedge clock);
    while (!fin && cyc < 4000) begin
      start = ($urandom_range(0, 7) == 0);
      start_address = {8'($urandom_range(0, 255)), $urandom};
      transfer_length = LW'($urandom_range(1, 4000));
      aw_ready = ($urandom_range(0, 3) != 0);
      case (mode)
        0: w_ready = 1'b1;
        1: w_ready = 1'($urandom_range(0, 1));
        default: begin w_ready = tog; tog = !tog; end
      endcase
      b_valid = b_phase ? (b_valid | ($urandom_range(0, 1) == 1)) : 1'b0;
      b_error = err_first && (b_count == 0);
      #1;
      if (cyc == 0) begin obs_busy1 = busy; obs_awv1 = aw_valid; obs_init1 = gen_initialize; end
      if (gen_initialize) obs_init++;
      if (gen_advance) obs_adv++;
      if (aw_stall && (!aw_valid || aw_address !== st_addr || aw_length !== st_len)) obs_stable_viol++;
      if (w_stall && (!w_valid || w_data !== st_data || w_strobe !== st_strb || w_last !== st_last))
        obs_stable_viol++;
      if (aw_valid && outstanding) obs_overlap++;
      aw_stall = aw_valid && !aw_ready; st_addr = aw_address; st_len = aw_length;
      w_stall = w_valid && !w_ready; st_data = w_data; st_strb = w_strobe; st_last = w_last;
      if (aw_valid && aw_ready) begin
        obs_aw_addr.push_back(aw_address); obs_aw_len.push_back(aw_length); outstanding = 1;
      end
      if (w_valid && w_ready) begin
        obs_data.push_back(w_data); obs_strobe.push_back(w_strobe); obs_last.push_back(w_last);
        if (w_last) b_phase = 1;
      end
      if (b_valid && b_ready) begin b_phase = 0; outstanding = 0; b_count++; last_hs = cyc; end
      if (done) begin fin = 1; obs_done_lat = cyc - last_hs; obs_busy_done = busy; obs_error = error; end
      @(negedge clock);
      cyc++;
    end
    obs_timeout = !fin;
    start = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_error = 1'b0;
    #1;
    obs_after_ok = !done && !busy && !aw_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    compared++;
    if ({busy, done, error, gen_initialize, gen_advance, aw_valid, w_valid, w_last, b_ready} !== 9'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b want 000000000",
               {busy, done, error, gen_initialize, gen_advance, aw_valid, w_valid, w_last, b_ready});
    end
    compared++;
    if (aw_address !== '0 || aw_length !== 8'd0) begin
      mismatched++; $display("[TB] FAIL reset_aw: got %h/%0d want 0/0", aw_address, aw_length);
    end
    compared++;
    if (gen_byte_mask !== {BPB{1'b1}}) begin
      mismatched++; $display("[TB] FAIL reset_mask: got %h want all ones", gen_byte_mask);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_burst;
    run_transfer(40'h1000, 24'd64, 0, 1'b0);
    compared++;
    if (obs_timeout) begin mismatched++; $display("[TB] FAIL single_timeout: got timeout want done"); end
    compared++;
    if (obs_aw_addr.size() != 1 || obs_aw_addr[0] !== 40'h1000 || obs_aw_len[0] !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL single_aw: got %0d bursts first %h/%0d want 1 burst 1000/1",
               obs_aw_addr.size(), obs_aw_addr[0], obs_aw_len[0]);
    end
    compared++;
    if (obs_strobe.size() != 2 || obs_strobe[0] !== '1 || obs_strobe[1] !== '1
        || obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_beats: got %0d beats strobe %h last %b%b want 2 beats ffffffff last 01",
               obs_strobe.size(), obs_strobe[1], obs_last[0], obs_last[1]);
    end
    compared++;
    if (obs_done_lat != 1 || obs_error !== 1'b0 || obs_busy_done) begin
      mismatched++;
      $display("[TB] FAIL single_done: got lat %0d err %b busy %b want 1/0/0", obs_done_lat, obs_error, obs_busy_done);
    end
    compared++;
    if (!obs_init1 || !obs_busy1 || !obs_awv1 || obs_init != 1) begin
      mismatched++;
      $display("[TB] FAIL single_start: got init %b busy %b awv %b inits %0d want 1/1/1/1",
               obs_init1, obs_busy1, obs_awv1, obs_init);
    end
  endtask

  task automatic test_multi_burst;
    int bad;
    run_transfer(40'h0, 24'd600, 1, 1'b0);
    compared++;
    if (obs_aw_addr.size() != 2 || obs_aw_addr[0] !== 40'h0 || obs_aw_len[0] !== 8'd15
        || obs_aw_addr[1] !== 40'h200 || obs_aw_len[1] !== 8'd2) begin
      mismatched++;
      $display("[TB] FAIL multi_aw: got %0d bursts %h/%0d %h/%0d want 0/15 200/2", obs_aw_addr.size(),
               obs_aw_addr[0], obs_aw_len[0], obs_aw_addr[1], obs_aw_len[1]);
    end
    compared++;
    if (obs_adv != 19) begin mismatched++; $display("[TB] FAIL multi_advance: got %0d want 19", obs_adv); end
    compared++;
    if (obs_strobe.size() != 19 || obs_strobe[18] !== 32'h00FFFFFF) begin
      mismatched++; $display("[TB] FAIL multi_tail: got %h want 00ffffff", obs_strobe[18]);
    end
    bad = 0;
    for (int k = 0; k < obs_last.size(); k++) if (obs_last[k] !== (k == 15 || k == 18)) bad++;
    compared++;
    if (bad != 0) begin mismatched++; $display("[TB] FAIL multi_last: got %0d wrong w_last want 0", bad); end
  endtask

  task automatic test_page_boundary;
    int crossing;
    run_transfer(40'hFC0, 24'd256, 1, 1'b0);
    compared++;
    if (obs_aw_addr.size() != 2 || obs_aw_addr[0] !== 40'hFC0 || obs_aw_len[0] !== 8'd1
        || obs_aw_addr[1] !== 40'h1000 || obs_aw_len[1] !== 8'd5) begin
      mismatched++;
      $display("[TB] FAIL page_aw: got %0d bursts %h/%0d %h/%0d want fc0/1 1000/5", obs_aw_addr.size(),
               obs_aw_addr[0], obs_aw_len[0], obs_aw_addr[1], obs_aw_len[1]);
    end
    crossing = 0;
    for (int k = 0; k < obs_aw_addr.size(); k++)
      if (int'(obs_aw_addr[k][11:0]) + (int'(obs_aw_len[k]) + 1) * BPB > 4096) crossing++;
    compared++;
    if (crossing != 0) begin mismatched++; $display("[TB] FAIL page_cross: got %0d want 0", crossing); end
  endtask

  task automatic test_stall;
    int bad;
    run_transfer(40'h2000, 24'd512, 2, 1'b0);
    compared++;
    if (obs_adv != 16 || obs_data.size() != 16) begin
      mismatched++; $display("[TB] FAIL stall_advance: got %0d/%0d want 16/16", obs_adv, obs_data.size());
    end
    compared++;
    if (obs_stable_viol != 0) begin
      mismatched++; $display("[TB] FAIL stall_stable: got %0d violations want 0", obs_stable_viol);
    end
    bad = 0;
    for (int k = 0; k < obs_data.size(); k++) if (obs_data[k] !== pattern_word(k, seed)) bad++;
    compared++;
    if (bad != 0) begin mismatched++; $display("[TB] FAIL stall_data: got %0d wrong beats want 0", bad); end
  endtask

  task automatic test_error;
    int exp_aws;
    exp_aws = ABORT_ON_ERROR ? 1 : 2;
    run_transfer(40'h0, 24'd1024, 1, 1'b1);
    compared++;
    if (obs_aw_addr.size() != exp_aws) begin
      mismatched++; $display("[TB] FAIL error_bursts: got %0d want %0d", obs_aw_addr.size(), exp_aws);
    end
    compared++;
    if (obs_timeout || obs_error !== 1'b1) begin
      mismatched++; $display("[TB] FAIL error_flag: got timeout %b err %b want 0/1", obs_timeout, obs_error);
    end
  endtask

  task automatic test_reset_mid;
    int waited;
    @(negedge clock);
    start = 1'b1; start_address = 40'h0; transfer_length = 24'd1024; aw_ready = 1'b1; w_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    waited = 0;
    while (!w_valid && waited < 20) begin @(negedge clock); waited++; end
    w_ready = 1'b1;
    @(negedge clock);
    compared++;
    if (w_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reach_data: got %b want 1", w_valid); end
    reset = 1'b1;
    #1;
    compared++;
    if ({busy, done, error, gen_initialize, gen_advance, aw_valid, w_valid, w_last, b_ready} !== 9'b0
        || aw_address !== '0 || aw_length !== 8'd0 || gen_byte_mask !== {BPB{1'b1}}) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got ctrl %b mask %h want 0 and all ones",
               {busy, done, error, gen_initialize, gen_advance, aw_valid, w_valid, w_last, b_ready}, gen_byte_mask);
    end
    @(negedge clock);
    w_ready = 1'b0; aw_ready = 1'b0; reset = 1'b0;
    @(negedge clock);
    start = 1'b1; transfer_length = '0;
    @(negedge clock);
    start = 1'b0;
    #1;
    compared++;
    if (done !== 1'b1 || busy !== 1'b0 || aw_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL zero_len: got done %b busy %b awv %b want 1/0/0", done, busy, aw_valid);
    end
    @(negedge clock);
    #1;
    compared++;
    if (done !== 1'b0 || aw_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL zero_len_after: got done %b awv %b want 0/0", done, aw_valid);
    end
  endtask

  task automatic test_random_transfers;
    logic [AW-1:0] addr, a;
    logic [LW-1:0] len;
    logic [BPB-1:0] strb;
    int mode, beats, total, tail, n, aw_bad, bad;
    bit err, exp_busy;
    logic [AW-1:0] exp_addr[$];
    logic [7:0] exp_len[$];
    bit exp_last[$];
    for (int t = 0; t < 24; t++) begin
      addr = {8'($urandom_range(0, 255)), $urandom};
      len = (t % 6 == 0) ? '0 : LW'($urandom_range(1, 1500));
      mode = $urandom_range(0, 2);
      err = ($urandom_range(0, 2) == 0);
      run_transfer(addr, len, mode, err);
      exp_addr.delete(); exp_len.delete(); exp_last.delete();
      a = addr & ~AW'(BPB - 1);
      total = (int'(len) + BPB - 1) / BPB;
      tail = int'(len) % BPB;
      beats = total;
      while (beats > 0) begin
        n = MAXB;
        if (beats < n) n = beats;
        if ((4096 - int'(a[11:0])) / BPB < n) n = (4096 - int'(a[11:0])) / BPB;
        exp_addr.push_back(a); exp_len.push_back(8'(n - 1));
        for (int j = 0; j < n; j++) exp_last.push_back(j == n - 1);
        a += AW'(n * BPB);
        beats -= n;
        if (ABORT_ON_ERROR && err) beats = 0;
      end
      exp_busy = (len != '0);
      compared++;
      if (obs_timeout || obs_done_lat != 1 || obs_busy_done || !obs_after_ok) begin
        mismatched++;
        $display("[TB] FAIL rand_done t%0d: got timeout %b lat %0d busy %b after %b want 0/1/0/1",
                 t, obs_timeout, obs_done_lat, obs_busy_done, obs_after_ok);
      end
      aw_bad = (obs_aw_addr.size() != exp_addr.size()) ? 1 : 0;
      for (int k = 0; k < exp_addr.size() && k < obs_aw_addr.size(); k++)
        if (obs_aw_addr[k] !== exp_addr[k] || obs_aw_len[k] !== exp_len[k]) aw_bad++;
      compared++;
      if (aw_bad != 0) begin
        mismatched++;
        $display("[TB] FAIL rand_aw t%0d: got %0d bursts (%0d wrong) want %0d", t, obs_aw_addr.size(), aw_bad, exp_addr.size());
      end
      bad = (obs_data.size() != exp_last.size()) ? 1 : 0;
      for (int k = 0; k < exp_last.size() && k < obs_data.size(); k++) begin
        strb = (k == total - 1 && tail != 0) ? BPB'((64'd1 << tail) - 64'd1) : '1;
        if (obs_strobe[k] !== strb || obs_last[k] !== exp_last[k]
            || obs_data[k] !== apply_mask(pattern_word(k, seed), strb)) bad++;
      end
      compared++;
      if (bad != 0 || obs_adv != exp_last.size()) begin
        mismatched++;
        $display("[TB] FAIL rand_beats t%0d: got %0d beats %0d advances %0d wrong want %0d beats 0 wrong",
                 t, obs_data.size(), obs_adv, bad, exp_last.size());
      end
      compared++;
      if (obs_error !== (err && exp_busy) || obs_busy1 != exp_busy || obs_awv1 != exp_busy
          || obs_init1 != exp_busy || obs_init != int'(exp_busy)) begin
        mismatched++;
        $display("[TB] FAIL rand_status t%0d: got err %b busy1 %b awv1 %b init %b/%0d want err %b others %b",
                 t, obs_error, obs_busy1, obs_awv1, obs_init1, obs_init, err && exp_busy, exp_busy);
      end
      compared++;
      if (obs_stable_viol != 0 || obs_overlap != 0) begin
        mismatched++;
        $display("[TB] FAIL rand_protocol t%0d: got stable %0d overlap %0d want 0/0", t, obs_stable_viol, obs_overlap);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_address = '0; transfer_length = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_error = 1'b0;
    test_reset;
    test_single_burst;
    test_multi_burst;
    test_page_boundary;
    test_stall;
    test_error;
    test_reset_mid;
    test_random_transfers;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
